branch_serial_cmp: RTL and testbench

BRANCH_SERIAL_CMP -- requirements
Module: branch_serial_cmp

---
 rtl/branch_cmp_pkg.sv | 35 +++
 rtl/branch_nibble_cmp.sv | 14 +
 rtl/branch_serial_cmp.sv | 143 ++++++++++++++
 tb/tb_branch_serial_cmp.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_cmp_pkg.sv
// Shared types and helpers for the serial branch comparator.
// Enumerates RISC-V branch funct3 codes and the comparator FSM states.
package branch_cmp_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_type_e;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_e;

  // Reserved funct3 codes (010/011) never take the branch.
  function automatic logic branch_taken(input logic [2:0] br_type,
                                        input logic       eq,
                                        input logic       blt);
    case (br_type)
      BR_BEQ:           branch_taken = eq;
      BR_BNE:           branch_taken = ~eq;
      BR_BLT, BR_BLTU:  branch_taken = blt;
      BR_BGE, BR_BGEU:  branch_taken = ~blt;
      default:          branch_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/branch_nibble_cmp.sv
// Combinational single-digit magnitude compare used by the serial comparator.
module branch_nibble_cmp
  import branch_cmp_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               eq,
  output logic               agt
);

  assign eq  = (a == b);
  assign agt = (a > b);

endmodule

// File: rtl/branch_serial_cmp.sv
// Digit-serial RISC-V branch comparator, one 4-bit digit per cycle, MSB first.
// Define CMP_EARLY_EXIT_EN to finish at the first unequal digit (variable latency).
module branch_serial_cmp
  import branch_cmp_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DIGIT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  input  logic [2:0]       br_type_i,
  input  logic             flush_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             taken_o,
  output logic             equal_o,
  output logic             alarger_o,
  output logic             blarger_o
);

  localparam int NDIG = WIDTH / DIGIT_W;
  localparam int IDX_W = $clog2(NDIG);
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NDIG - 1);

  state_e           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [2:0]       type_reg;

  logic [DIGIT_W-1:0] dig_a;
  logic [DIGIT_W-1:0] dig_b;
  logic [DIGIT_W-1:0] sign_flip;
  logic               dig_eq;
  logic               dig_agt;
  logic               fin_eq;
  logic               fin_agt;
  logic               fin_blt;
  logic               done_now;

  assign req_ready_o = (state == IDLE);
  assign rsp_valid_o = (state == DONE);

  // Flipping the top sign bit maps two's complement order onto unsigned order.
  assign sign_flip = {((type_reg == BR_BLT) || (type_reg == BR_BGE)) && (idx == TOP_IDX),
                      {(DIGIT_W-1){1'b0}}};
  assign dig_a = a_reg[idx*DIGIT_W +: DIGIT_W] ^ sign_flip;
  assign dig_b = b_reg[idx*DIGIT_W +: DIGIT_W] ^ sign_flip;

  branch_nibble_cmp u_nibble (
    .a   (dig_a),
    .b   (dig_b),
    .eq  (dig_eq),
    .agt (dig_agt)
  );

`ifdef CMP_EARLY_EXIT_EN
  assign fin_eq   = dig_eq;
  assign fin_agt  = dig_agt;
  assign done_now = !dig_eq || (idx == '0);
`else
  // Remembers the most significant unequal digit while the scan runs to the end.
  logic found;
  logic found_agt;

  assign fin_eq   = !found && dig_eq;
  assign fin_agt  = found ? found_agt : dig_agt;
  assign done_now = (idx == '0);
`endif
  assign fin_blt = !fin_eq && !fin_agt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      type_reg  <= '0;
      taken_o   <= 1'b0;
      equal_o   <= 1'b0;
      alarger_o <= 1'b0;
      blarger_o <= 1'b0;
`ifndef CMP_EARLY_EXIT_EN
      found     <= 1'b0;
      found_agt <= 1'b0;
`endif
    end else if (flush_i) begin
      state     <= IDLE;
      taken_o   <= 1'b0;
      equal_o   <= 1'b0;
      alarger_o <= 1'b0;
      blarger_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            a_reg    <= rs1_i;
            b_reg    <= rs2_i;
            type_reg <= br_type_i;
            idx      <= TOP_IDX;
            state    <= CMP;
`ifndef CMP_EARLY_EXIT_EN
            found     <= 1'b0;
            found_agt <= 1'b0;
`endif
          end
        end
        CMP: begin
`ifndef CMP_EARLY_EXIT_EN
          if (!found && !dig_eq) begin
            found     <= 1'b1;
            found_agt <= dig_agt;
          end
`endif
          if (done_now) begin
            state     <= DONE;
            equal_o   <= fin_eq;
            alarger_o <= fin_agt;
            blarger_o <= fin_blt;
            taken_o   <= branch_taken(type_reg, fin_eq, fin_blt);
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready_i) begin
            state     <= IDLE;
            taken_o   <= 1'b0;
            equal_o   <= 1'b0;
            alarger_o <= 1'b0;
            blarger_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_serial_cmp.sv
// Directed self-checking bench for branch_serial_cmp (WIDTH=32).
// Expected latencies follow CMP_EARLY_EXIT_EN when it is defined.
module tb_branch_serial_cmp;

`ifdef CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [2:0]  br_type = '0;
  logic        flush = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        taken, equal, alarger, blarger;

  int n_checks = 0;
  int n_fail = 0;

  branch_serial_cmp #(.WIDTH(32), .DIGIT_W(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .rs1_i       (rs1),
    .rs2_i       (rs2),
    .br_type_i   (br_type),
    .flush_i     (flush),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .taken_o     (taken),
    .equal_o     (equal),
    .alarger_o   (alarger),
    .blarger_o   (blarger)
  );

  always #5 clk = ~clk;

  // Issues one request, scrambles the operand inputs after acceptance and
  // returns the number of edges after E0 until rsp_valid is seen (capped at 40).
  task automatic do_req(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] t, output int lat);
    @(negedge clk);
    rs1 = a; rs2 = b; br_type = t; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; rs1 = ~a; rs2 = 32'h5A5A5A5A; br_type = 3'b010;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  // Runs one request and checks latency plus {equal,alarger,blarger,taken}.
  task automatic run_case(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] t, input int exp_lat, input logic [3:0] exp_flags);
    int lat;
    do_req(a, b, t, lat);
    n_checks++;
    if (lat !== exp_lat) begin
      n_fail++;
      $display("[TB] FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    n_checks++;
    if ({equal, alarger, blarger, taken} !== exp_flags) begin
      n_fail++;
      $display("[TB] FAIL %s flags {eq,agt,blt,taken}: got %b expected %b",
               name, {equal, alarger, blarger, taken}, exp_flags);
    end
    release_rsp();
    n_checks++;
    if ({req_ready, rsp_valid, equal, alarger, blarger, taken} !== 6'b100000) begin
      n_fail++;
      $display("[TB] FAIL %s return to idle: got %b expected 100000", name,
               {req_ready, rsp_valid, equal, alarger, blarger, taken});
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({req_ready, rsp_valid, equal, alarger, blarger, taken} !== 6'b100000) begin
      n_fail++;
      $display("[TB] FAIL reset outputs: got %b expected 100000",
               {req_ready, rsp_valid, equal, alarger, blarger, taken});
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_compare();
    run_case("beq_equal", 32'h12345678, 32'h12345678, 3'b000, 8, 4'b1001);
    run_case("blt_signed", 32'hFFFFFFFF, 32'h00000001, 3'b100, EARLY ? 1 : 8, 4'b0011);
    run_case("bltu", 32'hFFFFFFFF, 32'h00000001, 3'b110, EARLY ? 1 : 8, 4'b0100);
    run_case("bgeu", 32'h00000100, 32'h000000FF, 3'b111, EARLY ? 6 : 8, 4'b0101);
    run_case("bge_signed", 32'h80000000, 32'h7FFFFFFF, 3'b101, EARLY ? 1 : 8, 4'b0010);
    run_case("funct3_010", 32'h80000000, 32'h00000001, 3'b010, EARLY ? 1 : 8, 4'b0100);
    run_case("first_digit_wins", 32'h20000000, 32'h1FFFFFFF, 3'b110, EARLY ? 1 : 8, 4'b0100);
    run_case("bne_low_digit", 32'hABCDEF01, 32'hABCDEF02, 3'b001, 8, 4'b0011);
  endtask

  task automatic test_backpressure();
    int lat;
    logic [3:0] held;
    do_req(32'h00000001, 32'h00000002, 3'b001, lat);
    held = {equal, alarger, blarger, taken};
    n_checks++;
    if (held !== 4'b0011) begin
      n_fail++;
      $display("[TB] FAIL backpressure initial flags: got %b expected 0011", held);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({rsp_valid, req_ready, equal, alarger, blarger, taken} !== 6'b100011) begin
        n_fail++;
        $display("[TB] FAIL backpressure hold cycle %0d: got %b expected 100011", i,
                 {rsp_valid, req_ready, equal, alarger, blarger, taken});
      end
    end
    release_rsp();
    n_checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL backpressure release: got %b expected 10", {req_ready, rsp_valid});
    end
  endtask

  task automatic test_flush();
    int seen;
    @(negedge clk);
    rs1 = 32'hCAFEF00D; rs2 = 32'hCAFEF00D; br_type = 3'b001; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++;
    if ({req_ready, rsp_valid, equal, alarger, blarger, taken} !== 6'b100000) begin
      n_fail++;
      $display("[TB] FAIL flush to idle: got %b expected 100000",
               {req_ready, rsp_valid, equal, alarger, blarger, taken});
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("[TB] FAIL flush no response: got %0d valid cycles expected 0", seen);
    end
    // Flush in IDLE must suppress acceptance of a simultaneous request.
    @(negedge clk); req_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL flush blocks accept: req_ready got %b expected 1", req_ready);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    rs1 = 32'h0; rs2 = 32'h0; br_type = 3'b000; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, equal, alarger, blarger, taken} !== 6'b100000) begin
      n_fail++;
      $display("[TB] FAIL reset mid-cmp: got %b expected 100000",
               {req_ready, rsp_valid, equal, alarger, blarger, taken});
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("[TB] FAIL reset mid-cmp no response: got %0d valid cycles expected 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    run_case("b2b_first", 32'h00000010, 32'h00000001, 3'b101, EARLY ? 7 : 8, 4'b0101);
    run_case("b2b_second", 32'h00000001, 32'h00000010, 3'b100, EARLY ? 7 : 8, 4'b0011);
  endtask

  initial begin
    $display("[TB] starting branch_serial_cmp bench (early exit = %0d)", EARLY);
    test_reset();
    test_compare();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
